// File: rtl/fb_copy_pkg.sv
// rtl/fb_copy_pkg.sv - shared types and elaboration helpers for the frame-buffer copy engine
package fb_copy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

    function automatic int calc_bsel_w(input int nbuf);
        return (nbuf <= 2) ? 1 : $clog2(nbuf);
    endfunction

    function automatic bit params_ok(input int addr_w, input int data_w, input int nbuf,
                                     input int len, input int rd_lat);
        return (addr_w >= 1) && (addr_w <= 30) && (data_w >= 1) &&
               (nbuf >= 2) && (nbuf <= 8) &&
               (len >= 1) && (len <= (1 << addr_w)) &&
               (rd_lat >= 1) && (rd_lat <= 4);
    endfunction

endpackage

// File: rtl/fb_copy_delay.sv
// rtl/fb_copy_delay.sv - fixed-depth valid+data shift register matching the source read latency
module fb_copy_delay #(
    parameter int W     = 16,
    parameter int DEPTH = 1
) (
    input  logic         sysclk,
    input  logic         reset,
    input  logic         in_tvalid,
    input  logic [W-1:0] in_tdata,
    output logic         out_tvalid,
    output logic [W-1:0] out_tdata
);

    logic [DEPTH-1:0] vld;
    logic [W-1:0]     dat [DEPTH];

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_tvalid;
            dat[0] <= in_tdata;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_tvalid = vld[DEPTH-1];
    assign out_tdata  = dat[DEPTH-1];

endmodule

// File: rtl/fb_copy_dma.sv
// rtl/fb_copy_dma.sv - copies the last completed PPU frame buffer into VGA scan memory
// Optional source-buffer protection during a copy: FB_COPY_PROTECT_EN.
module fb_copy_dma
    import fb_copy_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NBUF   = 2,
    parameter int LEN    = 2**ADDR_W,
    parameter int RD_LAT = 1,
    localparam int BSEL_W = calc_bsel_w(NBUF)
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   ppu_v_blank,
    output logic [BSEL_W-1:0]      ppu_buf_sel,
    input  logic                   copy_req,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [NBUF*DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic                   wr_en,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   drop
);

    if (!params_ok(ADDR_W, DATA_W, NBUF, LEN, RD_LAT)) begin : g_param_check
        $error("fb_copy_dma: parameter out of legal range");
    end

    localparam logic [ADDR_W:0]   LAST_RD    = (ADDR_W+1)'(LEN-1);
    localparam logic [ADDR_W:0]   LAST_DRAIN = (ADDR_W+1)'(RD_LAT-1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [BSEL_W-1:0] SEL_LAST   = BSEL_W'(NBUF-1);
    localparam logic [BSEL_W-1:0] SEL_ONE    = BSEL_W'(1);

    copy_state_t       state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [BSEL_W-1:0] sel_q, sel_inc, src_q, src_start;
    logic              req_q, start, withhold;
    logic              dly_valid;
    logic [ADDR_W-1:0] dly_addr;

    assign start     = copy_req & ~req_q & (state_q == IDLE);
    assign sel_inc   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_ONE;
    assign src_start = (sel_q == '0) ? SEL_LAST : sel_q - SEL_ONE;
    assign busy      = (state_q == READ) | (state_q == DRAIN);
    assign done      = (state_q == DONE);

`ifdef FB_COPY_PROTECT_EN
    logic drop_q;
    assign withhold = ppu_v_blank & busy & (sel_inc == src_q);
    always_ff @(posedge sysclk) begin
        if (!reset) drop_q <= 1'b0;
        else        drop_q <= withhold;
    end
    assign drop = drop_q;
`else
    assign withhold = 1'b0;
    assign drop     = 1'b0;
`endif

    // Tracks copy_req through reset so a request held across reset needs a fresh edge.
    always_ff @(posedge sysclk) begin
        req_q <= copy_req;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (start) begin
                       state_d = READ;
                       cnt_d   = '0;
                   end
            READ:  if (cnt_q == LAST_RD) begin
                       state_d = DRAIN;
                       cnt_d   = '0;
                   end else begin
                       cnt_d = cnt_q + CNT_ONE;
                   end
            DRAIN: if (cnt_q == LAST_DRAIN) begin
                       state_d = DONE;
                       cnt_d   = '0;
                   end else begin
                       cnt_d = cnt_q + CNT_ONE;
                   end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) src_q <= src_start;
            if (ppu_v_blank && !withhold) sel_q <= sel_inc;
        end
    end

    assign ppu_buf_sel = sel_q;
    assign rd_addr     = (state_q == READ) ? cnt_q[ADDR_W-1:0] : '0;

    fb_copy_delay #(
        .W     (ADDR_W),
        .DEPTH (RD_LAT)
    ) u_delay (
        .sysclk     (sysclk),
        .reset      (reset),
        .in_tvalid  (state_q == READ),
        .in_tdata   (rd_addr),
        .out_tvalid (dly_valid),
        .out_tdata  (dly_addr)
    );

    assign wr_en   = dly_valid;
    assign wr_addr = dly_valid ? dly_addr : '0;

    always_comb begin
        wr_data = '0;
        for (int b = 0; b < NBUF; b++) begin
            if (src_q == BSEL_W'(b)) wr_data = rd_data[b*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_fb_copy_dma.sv
// tb/tb_fb_copy_dma.sv - directed self-checking bench for fb_copy_dma (two configurations)
module tb_fb_copy_dma;

    localparam int A_LEN = 256;
    localparam int A_LAT = 1;
    localparam int B_LEN = 16;
    localparam int B_LAT = 3;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    always #5 sysclk = ~sysclk;

    // instance A: NBUF=2, ADDR_W=8, LEN=256, RD_LAT=1
    logic        a_v_blank = 1'b0, a_copy_req = 1'b0;
    logic [0:0]  a_sel;
    logic [7:0]  a_rd_addr, a_wr_addr, a_wr_data, a_p1;
    logic [15:0] a_rd_data;
    logic        a_wr_en, a_busy, a_done, a_drop;

    // instance B: NBUF=4, ADDR_W=4, LEN=16, RD_LAT=3
    logic        b_v_blank = 1'b0, b_copy_req = 1'b0;
    logic [1:0]  b_sel;
    logic [3:0]  b_rd_addr, b_wr_addr, b_p1, b_p2, b_p3;
    logic [7:0]  b_wr_data;
    logic [31:0] b_rd_data;
    logic        b_wr_en, b_busy, b_done, b_drop;

    fb_copy_dma #(.ADDR_W(8), .DATA_W(8), .NBUF(2), .LEN(A_LEN), .RD_LAT(A_LAT)) u_a (
        .sysclk(sysclk), .reset(reset), .ppu_v_blank(a_v_blank), .ppu_buf_sel(a_sel),
        .copy_req(a_copy_req), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .wr_addr(a_wr_addr),
        .wr_en(a_wr_en), .wr_data(a_wr_data), .busy(a_busy), .done(a_done), .drop(a_drop)
    );

    fb_copy_dma #(.ADDR_W(4), .DATA_W(8), .NBUF(4), .LEN(B_LEN), .RD_LAT(B_LAT)) u_b (
        .sysclk(sysclk), .reset(reset), .ppu_v_blank(b_v_blank), .ppu_buf_sel(b_sel),
        .copy_req(b_copy_req), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .wr_addr(b_wr_addr),
        .wr_en(b_wr_en), .wr_data(b_wr_data), .busy(b_busy), .done(b_done), .drop(b_drop)
    );

    function automatic logic [7:0] mem(input int b, input int a);
        return 8'((a * 3 + b * 64 + 1) & 255);
    endfunction

    // source memories with RD_LAT cycles of read latency
    always @(posedge sysclk) begin
        a_p1 <= a_rd_addr;
        b_p1 <= b_rd_addr;
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end

    always_comb begin
        a_rd_data = '0;
        b_rd_data = '0;
        for (int b = 0; b < 2; b++) a_rd_data[b*8 +: 8] = mem(b, int'(a_p1));
        for (int b = 0; b < 4; b++) b_rd_data[b*8 +: 8] = mem(b, int'(b_p3));
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] pack(input logic [15:0] ra, input logic we, input logic [15:0] wa,
                                         input logic [7:0] wd, input logic bz, input logic dn);
        return {ra, 7'b0, we, wa, (we ? wd : 8'h00), 6'b0, bz, dn};
    endfunction

    // expected outputs k cycles after the start-event cycle T
    function automatic logic [55:0] exp_cycle(input int k, input int len, input int lat, input int src);
        logic [15:0] ra, wa;
        logic        we, bz, dn;
        logic [7:0]  wd;
        ra = (k >= 1 && k <= len) ? 16'(k - 1) : 16'h0;
        we = (k >= 1 + lat) && (k <= len + lat);
        wa = we ? 16'(k - 1 - lat) : 16'h0;
        wd = we ? mem(src, k - 1 - lat) : 8'h00;
        bz = (k >= 1) && (k <= len + lat);
        dn = (k == len + lat + 1);
        return pack(ra, we, wa, wd, bz, dn);
    endfunction

    function automatic logic [55:0] a_now();
        return pack(16'(a_rd_addr), a_wr_en, 16'(a_wr_addr), a_wr_data, a_busy, a_done);
    endfunction

    function automatic logic [55:0] b_now();
        return pack(16'(b_rd_addr), b_wr_en, 16'(b_wr_addr), b_wr_data, b_busy, b_done);
    endfunction

    typedef struct {
        int start_sel;
        bit vb;
        int exp_src;
        int exp_sel;
    } vec_t;

    vec_t vecs[4];
    int   b_sel_model = 0;
    int   a_sel_model = 0;
    int   a_src;

    initial begin
        vecs[0] = '{start_sel: 0, vb: 1'b0, exp_src: 3, exp_sel: 0};
        vecs[1] = '{start_sel: 2, vb: 1'b1, exp_src: 1, exp_sel: 3};
        vecs[2] = '{start_sel: 3, vb: 1'b0, exp_src: 2, exp_sel: 3};
        vecs[3] = '{start_sel: 0, vb: 1'b1, exp_src: 3, exp_sel: 1};

        repeat (3) @(negedge sysclk);
        check("reset_a_outputs", 64'(a_now()), 64'(pack(0, 0, 0, 0, 0, 0)));
        check("reset_b_outputs", 64'(b_now()), 64'(pack(0, 0, 0, 0, 0, 0)));
        check("reset_sel_drop", {60'b0, a_sel, b_sel, a_drop}, 64'h0);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);

        // table-driven source selection on instance B
        for (int v = 0; v < 4; v++) begin
            for (int n = 0; n < 8 && b_sel_model != vecs[v].start_sel; n++) begin
                b_v_blank = 1'b1;
                @(negedge sysclk);
                b_v_blank = 1'b0;
                b_sel_model = (b_sel_model + 1) % 4;
            end
            check($sformatf("b_vec%0d_start_sel", v), 64'(b_sel), 64'(vecs[v].start_sel));
            b_copy_req = 1'b1;
            b_v_blank  = vecs[v].vb;
            for (int k = 1; k <= B_LEN + B_LAT + 1; k++) begin
                @(negedge sysclk);
                b_v_blank = 1'b0;
                check($sformatf("b_vec%0d_k%0d", v, k), 64'(b_now()),
                      64'(exp_cycle(k, B_LEN, B_LAT, vecs[v].exp_src)));
                if (k == 1) check($sformatf("b_vec%0d_sel_after", v), 64'(b_sel), 64'(vecs[v].exp_sel));
            end
            b_sel_model = vecs[v].exp_sel;
            b_copy_req = 1'b0;
            repeat (2) @(negedge sysclk);
        end

        // instance A: full copy, ignored mid-copy edge, v-blank during copy, held request after done
        a_copy_req = 1'b1;
        for (int k = 1; k <= A_LEN + A_LAT + 9; k++) begin
            @(negedge sysclk);
            check($sformatf("a_copy_k%0d", k), 64'(a_now()), 64'(exp_cycle(k, A_LEN, A_LAT, 1)));
            if (k == 20) a_copy_req = 1'b0;
            if (k == 30) a_copy_req = 1'b1;
            if (k == 50) a_v_blank = 1'b1;
            if (k == 51) begin
                a_v_blank = 1'b0;
`ifdef FB_COPY_PROTECT_EN
                check("a_protect_sel_drop", {62'b0, a_sel, a_drop}, {62'b0, 1'b0, 1'b1});
                a_sel_model = 0;
`else
                check("a_protect_sel_drop", {62'b0, a_sel, a_drop}, {62'b0, 1'b1, 1'b0});
                a_sel_model = 1;
`endif
            end
            if (k == 52) check("a_drop_one_cycle", 64'(a_drop), 64'h0);
        end
        a_copy_req = 1'b0;
        repeat (2) @(negedge sysclk);

        // reset at word 100 of a copy, request held high through reset
        a_src = (a_sel_model == 0) ? 1 : 0;
        a_copy_req = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            @(negedge sysclk);
            check($sformatf("a_rst_copy_k%0d", k), 64'(a_now()), 64'(exp_cycle(k, A_LEN, A_LAT, a_src)));
        end
        reset = 1'b0;
        @(negedge sysclk);
        check("a_reset_mid_copy", 64'(a_now()), 64'(pack(0, 0, 0, 0, 0, 0)));
        check("reset_mid_sel", {62'b0, a_sel, b_sel}, 64'h0);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge sysclk);
            check($sformatf("a_held_req_k%0d", k), 64'(a_now()), 64'(pack(0, 0, 0, 0, 0, 0)));
        end
        a_copy_req = 1'b0;
        repeat (2) @(negedge sysclk);
        a_copy_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge sysclk);
            check($sformatf("a_fresh_edge_k%0d", k), 64'(a_now()), 64'(exp_cycle(k, A_LEN, A_LAT, 1)));
        end
        a_copy_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_copy_dma.md
# fb_copy_dma

Parametrised frame-buffer copy engine for the PPU/VGA path. The PPU renders into one of NBUF frame buffers, and the active buffer advances on every vertical blank. When the display side requests a frame, this block burst-copies the most recently completed buffer into the VGA scan memory. It is the generalised successor of the two-buffer VGA memory controller: buffer count, widths, copy length and read latency are configurable, and it adds a busy/done handshake and optional protection of the source buffer during a copy.

## Interface
Parameters:
- ADDR_W, 16, address width of the source and destination memories.
- DATA_W, 8, data word width.
- NBUF, 2, number of PPU frame buffers; legal range 2..8.
- LEN, 2**ADDR_W, words copied per request; legal range 1..2**ADDR_W.
- RD_LAT, 1, source read latency in cycles; legal range 1..4.

Ports:
- sysclk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- ppu_v_blank  in  1  frame-end strobe; each high cycle is one advance request.
- ppu_buf_sel  out  BSEL_W  buffer the PPU is currently writing.
- copy_req  in  1  level request from the VGA side; a copy starts on a rising edge.
- rd_addr  out  ADDR_W  source read address, shared by all buffers.
- rd_data  in  NBUF*DATA_W  read data; buffer b occupies bits [b*DATA_W +: DATA_W].
- wr_addr  out  ADDR_W  destination write address.
- wr_en  out  1  destination write strobe.
- wr_data  out  DATA_W  destination write data.
- busy  out  1  a copy is in progress.
- done  out  1  one-cycle pulse when a copy completes.
- drop  out  1  one-cycle pulse when a v-blank advance is withheld (only when FB_COPY_PROTECT_EN is defined).

## Operation
- BSEL_W = $clog2(NBUF).
- Reset values: ppu_buf_sel=0, all state registers zero, FSM in IDLE. rd_addr, wr_addr, wr_en, busy, done and drop are all 0.
- Edge detection: copy_req is registered into req_q. A start event is copy_req & ~req_q while in IDLE. Edges that occur while not in IDLE are ignored and are not queued.
- Source selection at the start event: src = (ppu_buf_sel + NBUF - 1) mod NBUF. This uses the pre-update value of ppu_buf_sel, including when a v-blank falls in the same cycle.
- Buffer advance: on any ppu_v_blank cycle, ppu_buf_sel <= (ppu_buf_sel + 1) mod NBUF, subject to the protection rule under Configuration.
- FSM states:
  - IDLE: a start event moves the FSM to READ with the read counter at 0.
  - READ: rd_addr = counter; the counter increments every cycle. When it reaches LEN-1 the FSM moves to DRAIN.
  - DRAIN: waits RD_LAT cycles for the read pipeline to empty, then moves to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Write path:
  - A valid/address delay line of exactly RD_LAT stages carries each issued read.
  - wr_en and wr_addr are the delayed valid and address.
  - wr_data = rd_data slice src, selected combinationally from the registered src.
- Width rules:
  - The read counter is ADDR_W+1 bits so that LEN = 2**ADDR_W does not overflow.
  - rd_addr is the low ADDR_W bits of the counter.
- Outputs outside READ:
  - rd_addr is 0 whenever the FSM is not in READ.
  - wr_addr is 0 whenever wr_en=0.
- busy = (state != IDLE) & (state != DONE).
- Reset mid-copy: at the next edge everything returns to its reset value, with no further writes. A copy_req held high through reset does not start a copy; a fresh rising edge is required.

## Timing
- Let T be the first cycle in which the start event is sampled.
- T+1: busy=1, rd_addr=0.
- Reads: rd_addr=i at cycle T+1+i, for i = 0..LEN-1.
- Writes: wr_en=1 with wr_addr=i at cycle T+1+i+RD_LAT. Writes are contiguous, with no gaps.
- Completion: done=1 at cycle T+LEN+RD_LAT+1, with busy=0 in the same cycle.
- Minimum spacing between copy starts is LEN+RD_LAT+2 cycles.
- ppu_buf_sel updates one cycle after the sampled ppu_v_blank.

## Configuration
- FB_COPY_PROTECT_EN defined:
  - While busy, a v-blank whose next buffer value equals src is withheld: ppu_buf_sel holds and drop pulses for one cycle.
  - With NBUF≥3 the PPU never overwrites the buffer being copied.
- FB_COPY_PROTECT_EN undefined:
  - ppu_buf_sel always advances on v-blank.
  - The drop port is tied to 0.

## Structure
- Package fb_copy_pkg holds:
  - the state enum (IDLE, READ, DRAIN, DONE);
  - the BSEL_W helper function;
  - parameter range checks, implemented as elaboration-time assertions.
- Sub-module fb_copy_delay: a generic RD_LAT-stage shift register for valid+address, instantiated once.

## Test plan
- Reset, then a copy_req rise with NBUF=2 and ppu_buf_sel=0 -> src=1. rd_addr runs 0..LEN-1. wr_data matches buffer 1 with a RD_LAT offset. done occurs exactly LEN+RD_LAT+1 cycles after T.
- RD_LAT=3, LEN=16 -> 16 contiguous wr_en cycles starting at T+4. done is at T+20. busy is low in the done cycle.
- copy_req toggled mid-copy and held high after done -> no second copy until a new rising edge.
- ppu_v_blank coincident with the start event, NBUF=4, ppu_buf_sel=2 -> src=1 and ppu_buf_sel becomes 3.
- Protection, NBUF=2: v-blank during a copy with FB_COPY_PROTECT_EN defined -> ppu_buf_sel holds and drop pulses. Same v-blank without the macro -> ppu_buf_sel toggles and drop stays 0.
- reset asserted at word 100 of a copy -> wr_en=0 and busy=0 at the next edge. No done pulse occurs.
